mem_access_stage: RTL

//  Memory-access (MEM) stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and drives the data-memory handshake.

---
 rtl/mem_access_stage.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: sequences single LW/SW accesses and mask-driven LM/SM bursts against the
// data-memory handshake, stalling upstream while busy, and registers the write-back bundle.
module mem_access_stage #(
    parameter logic [3:0] OP_LW = 4'b0100,
    parameter logic [3:0] OP_SW = 4'b0101,
    parameter logic [3:0] OP_LM = 4'b0110,
    parameter logic [3:0] OP_SM = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_ir,
    input  logic [15:0] in_alu_out,
    input  logic [15:0] in_rf_out1,
    input  logic [15:0] in_ra_out,
    input  logic [2:0]  in_write_add,
    input  logic        in_write_rf_n,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic        wb_valid,
    output logic        wb_write_rf_n,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MULTI  = 2'd2
    } stateType;

    stateType    stateReg, stateNext;
    logic        stallReg, stallNext;
    logic        memReqReg, memReqNext;
    logic        memWeReg, memWeNext;
    logic [15:0] memAddrReg, memAddrNext;
    logic [15:0] memWdataReg, memWdataNext;
    logic        wbValidReg, wbValidNext;
    logic        wbWriteRfNReg, wbWriteRfNNext;
    logic [2:0]  wbAddrReg, wbAddrNext;
    logic [15:0] wbDataReg, wbDataNext;
    logic [7:0]  maskReg, maskNext;
    logic [15:0] baseReg, baseNext;
    logic [3:0]  offsetReg, offsetNext;
    logic [2:0]  idxReg, idxNext;
    logic [2:0]  writeAddReg, writeAddNext;

    logic [3:0]  opcode;
    logic        isSingle;
    logic        isMulti;
    logic        acceptMulti;
    logic        beatDone;
    logic [7:0]  maskCleared;
    logic        unusedIrBits;

    assign opcode       = in_ir[15:12];
    assign isSingle     = (opcode == OP_LW) || (opcode == OP_SW);
    assign isMulti      = (opcode == OP_LM) || (opcode == OP_SM);
    assign acceptMulti  = (stateReg == IDLE) && in_valid && isMulti;
    assign beatDone     = (stateReg == MULTI) && (maskReg != 8'd0) && mem_ready;
    assign unusedIrBits = ^in_ir[11:8];

    // Mask with the bit of the beat currently on the bus removed.
    for (genvar gi = 0; gi < 8; gi++) begin : gClear
        assign maskCleared[gi] = maskReg[gi] && (idxReg != 3'(gi));
    end

    function automatic logic [2:0] lowestIdx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Beat index is kept apart from the datapath so the RF read index can lead the
    // registered store data by one cycle without forming a loop through rf_rd_data.
    always_comb begin
        idxNext = idxReg;
        if (acceptMulti) begin
            idxNext = lowestIdx(in_ir[7:0]);
        end else if (beatDone) begin
            idxNext = lowestIdx(maskCleared);
        end
    end

    assign rf_rd_addr = idxNext;

    always_comb begin
        stateNext      = stateReg;
        stallNext      = stallReg;
        memReqNext     = memReqReg;
        memWeNext      = memWeReg;
        memAddrNext    = memAddrReg;
        memWdataNext   = memWdataReg;
        wbValidNext    = 1'b0;
        wbWriteRfNNext = 1'b1;
        wbAddrNext     = wbAddrReg;
        wbDataNext     = wbDataReg;
        maskNext       = maskReg;
        baseNext       = baseReg;
        offsetNext     = offsetReg;
        writeAddNext   = writeAddReg;

        unique case (stateReg)
            IDLE: begin
                if (in_valid) begin
                    if (isSingle) begin
                        stateNext    = ACCESS;
                        stallNext    = 1'b1;
                        memReqNext   = 1'b1;
                        memWeNext    = (opcode == OP_SW);
                        memAddrNext  = in_alu_out;
                        memWdataNext = in_rf_out1;
                        writeAddNext = in_write_add;
                    end else if (isMulti) begin
                        // An empty mask still spends one stalled cycle in MULTI.
                        stateNext   = MULTI;
                        stallNext   = 1'b1;
                        maskNext    = in_ir[7:0];
                        baseNext    = in_ra_out;
                        offsetNext  = 4'd0;
                        memReqNext  = (in_ir[7:0] != 8'd0);
                        memWeNext   = (opcode == OP_SM);
                        memAddrNext = in_ra_out;
                        if (opcode == OP_SM) begin
                            memWdataNext = rf_rd_data;
                        end
                    end else begin
                        wbValidNext    = 1'b1;
                        wbWriteRfNNext = in_write_rf_n;
                        wbAddrNext     = in_write_add;
                        wbDataNext     = in_alu_out;
                    end
                end
            end

            ACCESS: begin
                if (mem_ready) begin
                    stateNext   = IDLE;
                    stallNext   = 1'b0;
                    memReqNext  = 1'b0;
                    wbValidNext = 1'b1;
                    wbAddrNext  = writeAddReg;
                    if (!memWeReg) begin
                        wbWriteRfNNext = 1'b0;
                        wbDataNext     = mem_rdata;
                    end
                end
            end

            MULTI: begin
                if (maskReg == 8'd0) begin
                    stateNext  = IDLE;
                    stallNext  = 1'b0;
                    memReqNext = 1'b0;
                end else if (mem_ready) begin
                    maskNext   = maskCleared;
                    offsetNext = offsetReg + 4'd1;
                    if (!memWeReg) begin
                        wbValidNext    = 1'b1;
                        wbWriteRfNNext = 1'b0;
                        wbAddrNext     = idxReg;
                        wbDataNext     = mem_rdata;
                    end
                    if (maskCleared == 8'd0) begin
                        stateNext  = IDLE;
                        stallNext  = 1'b0;
                        memReqNext = 1'b0;
                    end else begin
                        memAddrNext = baseReg + {12'd0, offsetReg + 4'd1};
                        if (memWeReg) begin
                            memWdataNext = rf_rd_data;
                        end
                    end
                end
            end

            default: begin
                stateNext  = IDLE;
                stallNext  = 1'b0;
                memReqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg      <= IDLE;
            stallReg      <= 1'b0;
            memReqReg     <= 1'b0;
            memWeReg      <= 1'b0;
            memAddrReg    <= 16'd0;
            memWdataReg   <= 16'd0;
            wbValidReg    <= 1'b0;
            wbWriteRfNReg <= 1'b1;
            wbAddrReg     <= 3'd0;
            wbDataReg     <= 16'd0;
            maskReg       <= 8'd0;
            baseReg       <= 16'd0;
            offsetReg     <= 4'd0;
            idxReg        <= 3'd0;
            writeAddReg   <= 3'd0;
        end else begin
            stateReg      <= stateNext;
            stallReg      <= stallNext;
            memReqReg     <= memReqNext;
            memWeReg      <= memWeNext;
            memAddrReg    <= memAddrNext;
            memWdataReg   <= memWdataNext;
            wbValidReg    <= wbValidNext;
            wbWriteRfNReg <= wbWriteRfNNext;
            wbAddrReg     <= wbAddrNext;
            wbDataReg     <= wbDataNext;
            maskReg       <= maskNext;
            baseReg       <= baseNext;
            offsetReg     <= offsetNext;
            idxReg        <= idxNext;
            writeAddReg   <= writeAddNext;
        end
    end

    assign stall_out     = stallReg;
    assign mem_req       = memReqReg;
    assign mem_we        = memWeReg;
    assign mem_addr      = memAddrReg;
    assign mem_wdata     = memWdataReg;
    assign wb_valid      = wbValidReg;
    assign wb_write_rf_n = wbWriteRfNReg;
    assign wb_addr       = wbAddrReg;
    assign wb_data       = wbDataReg;

endmodule
